// File: rtl/regfile_gp.sv
// regfile_gp -- general-purpose register file with an in-flight write scoreboard.
//
// Two combinational read ports feed operand fetch; one write port comes from
// write-back. Each register has a saturating pending-write counter: issue
// claims a target register, and the write-back write retires that claim. The
// busy flags let issue stall on RAW hazards.
//
// Ports:
//   iw_clk, iw_rst            clock; asynchronous active-high reset
//   iw_read_addr1/2           read indices
//   ow_read_data1/2           read data
//   ow_busy1/2                register at the read index has a pending write
//   iw_write_addr/data/enable write-back write port (also retires a claim)
//   iw_claim_addr/enable      issue claims a target register
//   ow_claim_ok               claim can be accepted (counter not saturated)
//   ow_err                    sticky: claim on saturated counter, or write at count 0
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   -> same-cycle write data is forwarded to matching read ports, and
//                busy drops in the cycle the last outstanding claim retires.
//   undefined -> reads and busy come only from registered state.

`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

// One pending-write counter. inc/dec in the same cycle cancel out, which is
// why that case never raises an error even at 0 or max.
module regfile_gp_entry #(
    parameter int PEND_BITS = 2
) (
    input  logic                 iw_clk,
    input  logic                 iw_rst,
    input  logic                 inc_i,
    input  logic                 dec_i,
    output logic [PEND_BITS-1:0] cnt_o,
    output logic                 err_o
);
    localparam logic [PEND_BITS-1:0] CNT_MAX = '1;

    logic [PEND_BITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
            else                  err_o = 1'b1;
        end else if (dec_i && !inc_i) begin
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            else             err_o = 1'b1;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module regfile_gp #(
    parameter int PEND_BITS = 2,
    parameter int NUM_REGS  = 2**`SIZE_TGT_GP
) (
    input  logic                    iw_clk,
    input  logic                    iw_rst,
    input  logic [`SIZE_TGT_GP-1:0] iw_read_addr1,
    output logic [`SIZE_DATA-1:0]   ow_read_data1,
    output logic                    ow_busy1,
    input  logic [`SIZE_TGT_GP-1:0] iw_read_addr2,
    output logic [`SIZE_DATA-1:0]   ow_read_data2,
    output logic                    ow_busy2,
    input  logic [`SIZE_TGT_GP-1:0] iw_write_addr,
    input  logic [`SIZE_DATA-1:0]   iw_write_data,
    input  logic                    iw_write_enable,
    input  logic [`SIZE_TGT_GP-1:0] iw_claim_addr,
    input  logic                    iw_claim_enable,
    output logic                    ow_claim_ok,
    output logic                    ow_err
);
    localparam logic [PEND_BITS-1:0] CNT_MAX = '1;

    logic [NUM_REGS-1:0][`SIZE_DATA-1:0] mem_q;
    logic [NUM_REGS-1:0][PEND_BITS-1:0]  cnt;
    logic [NUM_REGS-1:0]                 ent_err;
    logic                                err_q, err_d;

    // Per-register scoreboard counters.
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_ent
        regfile_gp_entry #(.PEND_BITS(PEND_BITS)) u_ent (
            .iw_clk (iw_clk),
            .iw_rst (iw_rst),
            .inc_i  (iw_claim_enable && (iw_claim_addr == `SIZE_TGT_GP'(r))),
            .dec_i  (iw_write_enable && (iw_write_addr == `SIZE_TGT_GP'(r))),
            .cnt_o  (cnt[r]),
            .err_o  (ent_err[r])
        );
    end

    // Data array: the write lands regardless of the counter state.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            mem_q <= '0;
        end else if (iw_write_enable) begin
            mem_q[iw_write_addr] <= iw_write_data;
        end
    end

    assign err_d = err_q | (|ent_err);

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign ow_err = err_q;

    // A same-cycle write to the claimed register frees a slot, so saturation
    // does not block that claim.
    assign ow_claim_ok = (cnt[iw_claim_addr] != CNT_MAX) ||
                         (iw_write_enable && (iw_write_addr == iw_claim_addr));

`ifdef REGFILE_BYPASS_EN
    logic wr_hit1, wr_hit2;
    logic retire1, retire2;

    assign wr_hit1 = iw_write_enable && (iw_write_addr == iw_read_addr1);
    assign wr_hit2 = iw_write_enable && (iw_write_addr == iw_read_addr2);

    // Busy drops early only when this write retires the last claim and no
    // new claim to the same register arrives in the same cycle.
    assign retire1 = wr_hit1 && (cnt[iw_read_addr1] == PEND_BITS'(1)) &&
                     !(iw_claim_enable && (iw_claim_addr == iw_read_addr1));
    assign retire2 = wr_hit2 && (cnt[iw_read_addr2] == PEND_BITS'(1)) &&
                     !(iw_claim_enable && (iw_claim_addr == iw_read_addr2));

    assign ow_read_data1 = wr_hit1 ? iw_write_data : mem_q[iw_read_addr1];
    assign ow_read_data2 = wr_hit2 ? iw_write_data : mem_q[iw_read_addr2];
    assign ow_busy1      = (cnt[iw_read_addr1] != '0) && !retire1;
    assign ow_busy2      = (cnt[iw_read_addr2] != '0) && !retire2;
`else
    assign ow_read_data1 = mem_q[iw_read_addr1];
    assign ow_read_data2 = mem_q[iw_read_addr2];
    assign ow_busy1      = (cnt[iw_read_addr1] != '0);
    assign ow_busy2      = (cnt[iw_read_addr2] != '0);
`endif
endmodule

// File: tb/tb_regfile_gp.sv
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 16
`endif

module tb_regfile_gp;
    logic                    iw_clk = 1'b0;
    logic                    iw_rst = 1'b0;
    logic [`SIZE_TGT_GP-1:0] iw_read_addr1 = '0, iw_read_addr2 = '0;
    logic [`SIZE_DATA-1:0]   ow_read_data1, ow_read_data2;
    logic                    ow_busy1, ow_busy2;
    logic [`SIZE_TGT_GP-1:0] iw_write_addr = '0, iw_claim_addr = '0;
    logic [`SIZE_DATA-1:0]   iw_write_data = '0;
    logic                    iw_write_enable = 1'b0, iw_claim_enable = 1'b0;
    logic                    ow_claim_ok, ow_err;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_gp dut (
        .iw_clk          (iw_clk),
        .iw_rst          (iw_rst),
        .iw_read_addr1   (iw_read_addr1),
        .ow_read_data1   (ow_read_data1),
        .ow_busy1        (ow_busy1),
        .iw_read_addr2   (iw_read_addr2),
        .ow_read_data2   (ow_read_data2),
        .ow_busy2        (ow_busy2),
        .iw_write_addr   (iw_write_addr),
        .iw_write_data   (iw_write_data),
        .iw_write_enable (iw_write_enable),
        .iw_claim_addr   (iw_claim_addr),
        .iw_claim_enable (iw_claim_enable),
        .ow_claim_ok     (ow_claim_ok),
        .ow_err          (ow_err)
    );

    always #5 iw_clk = ~iw_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change #1 after the edge; checks happen after a further settle.
    task automatic tick();
        @(posedge iw_clk);
        #1;
    endtask

    task automatic do_claim(input logic [`SIZE_TGT_GP-1:0] a);
        iw_claim_addr = a; iw_claim_enable = 1'b1;
        tick();
        iw_claim_enable = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [`SIZE_TGT_GP-1:0] a, input logic [`SIZE_DATA-1:0] d);
        iw_write_addr = a; iw_write_data = d; iw_write_enable = 1'b1;
        tick();
        iw_write_enable = 1'b0;
        #1;
    endtask

    initial begin
        // Reset values
        #2 iw_rst = 1'b1;
        #1;
        chk("rst_rd1",     ow_read_data1, 0);
        chk("rst_rd2",     ow_read_data2, 0);
        chk("rst_busy1",   ow_busy1, 0);
        chk("rst_busy2",   ow_busy2, 0);
        chk("rst_claimok", ow_claim_ok, 1);
        chk("rst_err",     ow_err, 0);
        tick(); tick();
        iw_rst = 1'b0;
        #1;

        // Dual port: claim r1, r2, then write them
        do_claim(4'd1);
        do_claim(4'd2);
        iw_read_addr1 = 4'd2; iw_read_addr2 = 4'd1; #1;
        chk("dp_busy1_claimed", ow_busy1, 1);
        chk("dp_busy2_claimed", ow_busy2, 1);
        do_write(4'd1, 16'h0011);
        do_write(4'd2, 16'h0022);
        chk("dp_rd1", ow_read_data1, 16'h0022);
        chk("dp_rd2", ow_read_data2, 16'h0011);
        chk("dp_busy1", ow_busy1, 0);
        chk("dp_err", ow_err, 0);

        // Claim/retire r5: claim at cycle 0, write at cycle 3
        iw_read_addr1 = 4'd5; #1;
        do_claim(4'd5);
        chk("cr_busy_c1", ow_busy1, 1);
        tick();
        chk("cr_busy_c2", ow_busy1, 1);
        tick();
        iw_write_addr = 4'd5; iw_write_data = 16'h0123; iw_write_enable = 1'b1; #1;
`ifdef REGFILE_BYPASS_EN
        chk("cr_busy_c3", ow_busy1, 0);
        chk("cr_rd_c3",   ow_read_data1, 16'h0123);
`else
        chk("cr_busy_c3", ow_busy1, 1);
        chk("cr_rd_c3",   ow_read_data1, 0);
`endif
        tick();
        iw_write_enable = 1'b0; #1;
        chk("cr_busy_c4", ow_busy1, 0);
        chk("cr_rd_c4",   ow_read_data1, 16'h0123);

        // Simultaneous claim+write on r2 with cnt=1
        iw_read_addr1 = 4'd2; #1;
        do_claim(4'd2);
        iw_claim_addr = 4'd2; iw_claim_enable = 1'b1;
        iw_write_addr = 4'd2; iw_write_data = 16'h0222; iw_write_enable = 1'b1;
        tick();
        iw_claim_enable = 1'b0; iw_write_enable = 1'b0; #1;
        chk("sim_busy", ow_busy1, 1);
        chk("sim_rd",   ow_read_data1, 16'h0222);
        chk("sim_err",  ow_err, 0);
        do_write(4'd2, 16'h0333);
        chk("sim_busy_clear", ow_busy1, 0);
        chk("sim_err_after",  ow_err, 0);

        // Saturation on r7
        iw_read_addr2 = 4'd7; #1;
        do_claim(4'd7);
        do_claim(4'd7);
        iw_claim_addr = 4'd7; #1;
        chk("sat_ok_at2", ow_claim_ok, 1);
        do_claim(4'd7);
        iw_claim_addr = 4'd7; #1;
        chk("sat_ok_at3", ow_claim_ok, 0);
        iw_write_addr = 4'd7; iw_write_enable = 1'b1; #1;
        chk("sat_ok_with_wr", ow_claim_ok, 1);
        iw_write_enable = 1'b0; #1;
        chk("sat_err_before", ow_err, 0);
        do_claim(4'd7);
        chk("sat_err", ow_err, 1);
        do_write(4'd7, 16'h0007);
        chk("sat_busy_w1", ow_busy2, 1);
        do_write(4'd7, 16'h0007);
        chk("sat_busy_w2", ow_busy2, 1);
        do_write(4'd7, 16'h0007);
        chk("sat_busy_w3", ow_busy2, 0);

        // Mid-run async reset with r3=0x00A5, cnt[3]=2
        do_claim(4'd3);
        do_claim(4'd3);
        do_claim(4'd3);
        do_write(4'd3, 16'h00A5);
        iw_read_addr1 = 4'd3; iw_read_addr2 = 4'd1; iw_claim_addr = 4'd3; #1;
        chk("mr_pre_rd",   ow_read_data1, 16'h00A5);
        chk("mr_pre_busy", ow_busy1, 1);
        iw_rst = 1'b1; #1;
        chk("mr_rd1",     ow_read_data1, 0);
        chk("mr_rd2",     ow_read_data2, 0);
        chk("mr_busy1",   ow_busy1, 0);
        chk("mr_busy2",   ow_busy2, 0);
        chk("mr_err",     ow_err, 0);
        chk("mr_claimok", ow_claim_ok, 1);
        tick();
        iw_rst = 1'b0; #1;

        // Underflow: write r9 with cnt 0
        iw_read_addr1 = 4'd9; #1;
        do_write(4'd9, 16'h0042);
        chk("uf_rd",   ow_read_data1, 16'h0042);
        chk("uf_busy", ow_busy1, 0);
        chk("uf_err",  ow_err, 1);
        tick(); tick(); tick();
        chk("uf_err_sticky", ow_err, 1);
        iw_rst = 1'b1; #1;
        chk("uf_err_cleared", ow_err, 0);
        tick();
        iw_rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_gp.md
# regfile_gp

General-purpose register file with in-flight write scoreboard. It receives the write port driven by the write-back stage (address, data, enable) and serves two asynchronous read ports to the decode/operand-fetch stage. Each register carries a small pending-write counter: the issue logic claims a target register when an instruction enters the pipe, and the write-back write retires the claim. The per-port busy flags let issue stall on RAW hazards.

## Interface
Parameters:
- PEND_BITS, 2: width of each per-register pending counter; saturates at 2**PEND_BITS-1 (3).
- NUM_REGS, 2**`SIZE_TGT_GP: number of GP registers.

Ports:
- iw_clk  in  1  clock; all state updates on posedge.
- iw_rst  in  1  reset, asynchronous, active-high.
- iw_read_addr1  in  `SIZE_TGT_GP  read port 1 register index.
- ow_read_data1  out  `SIZE_DATA  read port 1 data.
- ow_busy1  out  1  register at iw_read_addr1 has a pending write.
- iw_read_addr2  in  `SIZE_TGT_GP  read port 2 register index.
- ow_read_data2  out  `SIZE_DATA  read port 2 data.
- ow_busy2  out  1  register at iw_read_addr2 has a pending write.
- iw_write_addr  in  `SIZE_TGT_GP  from write-back gp_write_addr.
- iw_write_data  in  `SIZE_DATA  from write-back gp_write_data.
- iw_write_enable  in  1  from write-back gp_write_enable.
- iw_claim_addr  in  `SIZE_TGT_GP  target register of the instruction being issued.
- iw_claim_enable  in  1  issue claims iw_claim_addr this cycle.
- ow_claim_ok  out  1  claim at iw_claim_addr can be accepted (counter not saturated).
- ow_err  out  1  sticky error: claim on saturated counter or write with counter 0.

## Operation
- Storage: NUM_REGS x `SIZE_DATA array; all registers writable, none hardwired.
- Write: on posedge with iw_write_enable=1, array[iw_write_addr] <= iw_write_data.
- Read: ow_read_dataN = array[iw_read_addrN], combinational (bypass per Configuration).
- Pending counter cnt[r], per register, updated on posedge:
  - claim only (iw_claim_enable=1, r=iw_claim_addr): cnt+1 if cnt<max; if cnt==max, unchanged and ow_err set.
  - write only (iw_write_enable=1, r=iw_write_addr): cnt-1 if cnt>0; if cnt==0, unchanged, data still written, ow_err set.
  - claim and write to same r in same cycle: cnt unchanged, no error (even at 0 or max).
  - claim and write to different registers: both updates apply independently.
- ow_busyN = (cnt[iw_read_addrN] != 0), combinational from registered counters (adjusted per Configuration).
- ow_claim_ok = (cnt[iw_claim_addr] != max) or (iw_write_enable and iw_write_addr==iw_claim_addr); combinational. Issue must not assert iw_claim_enable when ow_claim_ok=0.
- ow_err: set on either error condition, cleared only by iw_rst.

## Timing
- Reset: all array entries 0, all cnt 0, ow_err 0; hence ow_read_data1/2 = 0, ow_busy1/2 = 0, ow_claim_ok = 1 while in reset.
- Reset asserted mid-operation clears all state asynchronously; pending claims are lost; the pipeline is reset simultaneously.
- Write latency: data written at edge N is visible on reads from after edge N (no-bypass), or during cycle N (bypass).
- Claim latency: claim at edge N makes busy visible from after edge N.
- Reads never stall and carry no handshake; iw_claim_enable/iw_write_enable are single-cycle qualifiers, one event per cycle each.

## Configuration
- REGFILE_BYPASS_EN defined: when iw_write_enable=1 and iw_write_addr==iw_read_addrN, ow_read_dataN = iw_write_data in the same cycle; ow_busyN is forced 0 if cnt[iw_read_addrN]==1 and that write retires it (no claim to the same register that cycle). Both ports bypass independently.
- Not defined: reads and busy come only from registered state; a same-cycle write is visible one cycle later.

## Test plan
- Reset: assert iw_rst mid-run with r3=0x00A5, cnt[3]=2 -> all reads 0, busy 0, ow_err 0, ow_claim_ok 1.
- Claim/retire: claim r5 at cycle 0, write r5=0x0123 at cycle 3 -> ow_busy1 (addr 5) 1 in cycles 1-3, 0 from cycle 4; read 0x0123 from cycle 4 (no bypass) or cycle 3 with bus busy 0 in cycle 3 (bypass).
- Saturation: claim r7 three times -> ow_claim_ok 0; fourth claim -> cnt stays 3, ow_err 1; three writes -> busy clears after third.
- Simultaneous claim+write on r2 with cnt=1 -> cnt stays 1, ow_busy 1, data updated, ow_err 0.
- Underflow: write r9=0x0042 with cnt 0 -> data 0x0042 read back, ow_err 1 and stays 1 until reset.
- Dual port: write r1=0x0011, r2=0x0022; read addr1=2, addr2=1 -> ow_read_data1=0x0022, ow_read_data2=0x0011.
